// File: rtl/pb_conditioner.sv
// Pushbutton conditioner for a stopwatch front panel.
// Synchronizes a raw active-low button, debounces both edges, and classifies
// each press as short (toggles run on release) or long (clears the counter
// once the hold threshold is reached).
`timescale 1ns/1ps

module pb_conditioner #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic pressed,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic run
);

  localparam int CNT_W = 27;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_flag_q, long_flag_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             short_pulse_q, short_pulse_d;
  logic             long_pulse_q, long_pulse_d;
  logic             run_q, run_d;
  logic             pb_s;

  assign pb_s = sync2_q;

  // Next-state and next-output logic for the synchronizer and the press FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    sync1_d       = pb_n;
    sync2_d       = sync1_q;
    state_d       = state_q;
    deb_cnt_d     = deb_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    long_flag_d   = long_flag_q;
    pressed_d     = pressed_q;
    run_d         = run_q;
    press_pulse_d = 1'b0;
    short_pulse_d = 1'b0;
    long_pulse_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!pb_s) begin
          state_d   = PRESS_DB;
          deb_cnt_d = '0;
        end
      end

      PRESS_DB: begin
        if (pb_s) begin
          // Low level did not last the debounce window: drop it silently.
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = HELD;
          press_pulse_d = 1'b1;
          pressed_d     = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end

      HELD: begin
        if (pb_s) begin
          // hold_cnt keeps its value so a release bounce resumes the hold.
          state_d   = REL_DB;
          deb_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d      = LONG;
          long_pulse_d = 1'b1;
          long_flag_d  = 1'b1;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end

      LONG: begin
        if (pb_s) begin
          state_d   = REL_DB;
          deb_cnt_d = '0;
        end
      end

      REL_DB: begin
        if (!pb_s) begin
          state_d = long_flag_q ? LONG : HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          pressed_d   = 1'b0;
          long_flag_d = 1'b0;
          if (!long_flag_q) begin
            short_pulse_d = 1'b1;
            run_d         = ~run_q;
          end
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces an idle, released button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchronizer resets to the released (high) level so reset itself
      // never looks like a falling edge.
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= IDLE;
      deb_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      long_flag_q   <= 1'b0;
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
      short_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      deb_cnt_q     <= deb_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_flag_q   <= long_flag_d;
      pressed_q     <= pressed_d;
      press_pulse_q <= press_pulse_d;
      short_pulse_q <= short_pulse_d;
      long_pulse_q  <= long_pulse_d;
      run_q         <= run_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = press_pulse_q;
  assign short_pulse = short_pulse_q;
  assign long_pulse  = long_pulse_q;
  assign run         = run_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DEB_CYCLES=4, LONG_CYCLES=20.
// A monitor samples the strobes 1 ns after each rising edge and records how
// many occurred and on which cycle; scenario tasks drive pb_n on falling edges
// and compare against hand-derived counts and latencies.
`timescale 1ns/1ps

module tb_pb_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic pb_n;
  logic pressed, press_pulse, short_pulse, long_pulse, run;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int press_total = 0, short_total = 0, long_total = 0;
  int press_last = -1, short_last = -1, long_last = -1;

  logic exp_run = 1'b0;

  pb_conditioner #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_n       (pb_n),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .run        (run)
  );

  always #5 clk = ~clk;

  // Cycle n is the n-th rising edge; strobes are sampled just after it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (press_pulse) begin press_total = press_total + 1; press_last = cyc; end
    if (short_pulse) begin short_total = short_total + 1; short_last = cyc; end
    if (long_pulse)  begin long_total  = long_total + 1;  long_last  = cyc; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with the button released: everything quiet and the FSM idle.
  task automatic test_reset();
    logic [4:0] outs;
    rst  = 1'b0;
    pb_n = 1'b1;
    cycles(3);
    outs = {pressed, press_pulse, short_pulse, long_pulse, run};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_asserted_outputs got %b want 00000", outs);
    end
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      outs = {pressed, press_pulse, short_pulse, long_pulse, run};
      checks++;
      if (outs !== 5'b0 || dut.state_q !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d outputs %b state %0d want 00000 state 0",
                 i, outs, dut.state_q);
      end
    end
  endtask

  // A 3-cycle low is shorter than the debounce window and must vanish.
  task automatic test_glitch();
    int p0 = press_total;
    int pressed_hi = 0;
    @(negedge clk);
    pb_n = 1'b0;
    cycles(3);
    pb_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pressed) pressed_hi++;
    end
    checks++;
    if (press_total - p0 !== 0) begin
      errors++;
      $display("FAIL glitch_press_pulse got %0d want 0", press_total - p0);
    end
    checks++;
    if (pressed_hi !== 0) begin
      errors++;
      $display("FAIL glitch_pressed got %0d high cycles want 0", pressed_hi);
    end
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL glitch_run got %b want 0", run);
    end
  endtask

  // Clean 12-cycle press: press 7 after the fall, short 7 after the rise, run toggles.
  task automatic test_short_press(input string tag);
    int p0 = press_total, s0 = short_total, l0 = long_total;
    int fall, rise;
    @(negedge clk);
    pb_n = 1'b0;
    fall = cyc;
    cycles(12);
    checks++;
    if (pressed !== 1'b1) begin
      errors++;
      $display("FAIL %s_pressed_while_held got %b want 1", tag, pressed);
    end
    pb_n = 1'b1;
    rise = cyc;
    cycles(15);
    exp_run = ~exp_run;
    checks++;
    if (press_total - p0 !== 1 || press_last - fall !== 7) begin
      errors++;
      $display("FAIL %s_press_pulse count %0d latency %0d want 1 and 7",
               tag, press_total - p0, press_last - fall);
    end
    checks++;
    if (short_total - s0 !== 1 || short_last - rise !== 7) begin
      errors++;
      $display("FAIL %s_short_pulse count %0d latency %0d want 1 and 7",
               tag, short_total - s0, short_last - rise);
    end
    checks++;
    if (long_total - l0 !== 0) begin
      errors++;
      $display("FAIL %s_long_pulse got %0d want 0", tag, long_total - l0);
    end
    checks++;
    if (run !== exp_run || pressed !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_release run %b pressed %b want run %b pressed 0",
               tag, run, pressed, exp_run);
    end
  endtask

  // 40-cycle hold: long_pulse 20 after press_pulse, no short, run unchanged.
  task automatic test_long_press();
    int p0 = press_total, s0 = short_total, l0 = long_total;
    int fall;
    @(negedge clk);
    pb_n = 1'b0;
    fall = cyc;
    cycles(40);
    checks++;
    if (pressed !== 1'b1) begin
      errors++;
      $display("FAIL long_pressed_while_held got %b want 1", pressed);
    end
    pb_n = 1'b1;
    cycles(15);
    checks++;
    if (press_total - p0 !== 1 || press_last - fall !== 7) begin
      errors++;
      $display("FAIL long_press_pulse count %0d latency %0d want 1 and 7",
               press_total - p0, press_last - fall);
    end
    checks++;
    if (long_total - l0 !== 1 || long_last - press_last !== 20) begin
      errors++;
      $display("FAIL long_long_pulse count %0d delay %0d want 1 and 20",
               long_total - l0, long_last - press_last);
    end
    checks++;
    if (short_total - s0 !== 0) begin
      errors++;
      $display("FAIL long_short_pulse got %0d want 0", short_total - s0);
    end
    checks++;
    if (run !== exp_run || pressed !== 1'b0) begin
      errors++;
      $display("FAIL long_after_release run %b pressed %b want run %b pressed 0",
               run, pressed, exp_run);
    end
  endtask

  // Release with 6 cycles of 1/0 bounce: pressed holds, one short_pulse.
  task automatic test_release_bounce();
    int p0 = press_total, s0 = short_total, l0 = long_total;
    int low_seen = 0;
    int rise;
    @(negedge clk);
    pb_n = 1'b0;
    cycles(12);
    for (int i = 0; i < 6; i++) begin
      pb_n = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (!pressed) low_seen++;
    end
    pb_n = 1'b1;
    rise = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!pressed) low_seen++;
    end
    checks++;
    if (low_seen !== 0) begin
      errors++;
      $display("FAIL bounce_pressed_dropped got %0d low cycles want 0", low_seen);
    end
    cycles(10);
    exp_run = ~exp_run;
    checks++;
    if (short_total - s0 !== 1 || short_last - rise !== 7) begin
      errors++;
      $display("FAIL bounce_short_pulse count %0d latency %0d want 1 and 7",
               short_total - s0, short_last - rise);
    end
    checks++;
    if (press_total - p0 !== 1 || long_total - l0 !== 0) begin
      errors++;
      $display("FAIL bounce_other_strobes press %0d long %0d want 1 and 0",
               press_total - p0, long_total - l0);
    end
    checks++;
    if (run !== exp_run || pressed !== 1'b0) begin
      errors++;
      $display("FAIL bounce_after_release run %b pressed %b want run %b pressed 0",
               run, pressed, exp_run);
    end
  endtask

  // Reset pulsed mid-hold (hold_cnt=10): silent during reset, fresh press after.
  task automatic test_reset_mid_press();
    int p0, s0, l0;
    int rel, rise;
    logic [4:0] outs;
    @(negedge clk);
    pb_n = 1'b0;
    cycles(17);
    checks++;
    if (dut.hold_cnt_q !== 27'd10) begin
      errors++;
      $display("FAIL midrst_hold_cnt got %0d want 10", dut.hold_cnt_q);
    end
    rst = 1'b0;
    #1;
    p0 = press_total; s0 = short_total; l0 = long_total;
    outs = {pressed, press_pulse, short_pulse, long_pulse, run};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs_in_reset got %b want 00000", outs);
    end
    cycles(2);
    outs = {pressed, press_pulse, short_pulse, long_pulse, run};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs_end_of_reset got %b want 00000", outs);
    end
    rst = 1'b1;
    rel = cyc;
    cycles(15);
    checks++;
    if (press_total - p0 !== 1 || press_last - rel !== 7) begin
      errors++;
      $display("FAIL midrst_new_press count %0d latency %0d want 1 and 7",
               press_total - p0, press_last - rel);
    end
    checks++;
    if (long_total - l0 !== 0 || short_total - s0 !== 0) begin
      errors++;
      $display("FAIL midrst_stray_strobes long %0d short %0d want 0 and 0",
               long_total - l0, short_total - s0);
    end
    pb_n = 1'b1;
    rise = cyc;
    cycles(15);
    exp_run = 1'b1;
    checks++;
    if (short_total - s0 !== 1 || short_last - rise !== 7 || run !== exp_run) begin
      errors++;
      $display("FAIL midrst_release short %0d latency %0d run %b want 1, 7, run 1",
               short_total - s0, short_last - rise, run);
    end
  endtask

  initial begin
    rst  = 1'b0;
    pb_n = 1'b1;
    test_reset();
    test_glitch();
    test_short_press("short1");
    test_short_press("short2");
    test_long_press();
    test_release_bounce();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 1000000, giving the debounce stability window in clk cycles (20 ms at 50 MHz).
REQ-002 The module SHALL have parameter LONG_CYCLES, default 100000000, giving the long-press threshold in clk cycles measured from the debounced press (2 s at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pb_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
REQ-006 pressed  output  1  debounced button level, 1 = held.
REQ-007 press_pulse  output  1  one-cycle strobe on the debounced press.
REQ-008 short_pulse  output  1  one-cycle strobe on the debounced release of a press shorter than LONG_CYCLES.
REQ-009 long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES; drives the downstream counter clear.
REQ-010 run  output  1  start/stop level for the downstream stopwatch counter, 1 = counting.

Function
REQ-011 pb_n SHALL pass through a 2-flop synchronizer, giving pb_s; both flops reset to 1.
REQ-012 The FSM SHALL have five states: IDLE, PRESS_DB, HELD, LONG, REL_DB.
REQ-013 Two counters SHALL be used: deb_cnt and hold_cnt, each 27 bits. Both counters SHALL saturate rather than wrap.
REQ-014 IDLE: if pb_s==0, the FSM SHALL go to PRESS_DB and clear deb_cnt.
REQ-015 PRESS_DB: if pb_s==1, the FSM SHALL return to IDLE with no output (glitch rejected). Otherwise deb_cnt SHALL increment.
REQ-016 PRESS_DB: when deb_cnt==DEB_CYCLES-1 with pb_s==0, the FSM SHALL go to HELD, pulse press_pulse, set pressed, and clear hold_cnt.
REQ-017 HELD: while pb_s==0, hold_cnt SHALL increment.
REQ-018 HELD: when hold_cnt==LONG_CYCLES-1, the FSM SHALL go to LONG, pulse long_pulse, and set an internal long_flag.
REQ-019 HELD: if pb_s==1, the FSM SHALL go to REL_DB and clear deb_cnt; hold_cnt SHALL hold its value.
REQ-020 LONG: if pb_s==1, the FSM SHALL go to REL_DB and clear deb_cnt.
REQ-021 REL_DB: if pb_s==0, the FSM SHALL return to LONG if long_flag is set, else to HELD, with hold_cnt resuming from its held value.
REQ-022 REL_DB: after DEB_CYCLES consecutive cycles of pb_s==1, the FSM SHALL go to IDLE and clear pressed and long_flag.
REQ-023 REL_DB exit: if long_flag==0, short_pulse SHALL pulse and run SHALL toggle in the same cycle.
REQ-024 Each press SHALL produce at most one press_pulse and exactly one of short_pulse or long_pulse; short_pulse and long_pulse SHALL never both occur for one press.
REQ-025 long_pulse SHALL NOT change run.
REQ-026 All outputs SHALL be registered.
REQ-027 Latency from a pb_n fall to press_pulse SHALL be 2 (sync) + 1 + DEB_CYCLES cycles, given a stable input.
REQ-028 DEB_CYCLES SHALL be at least 2, and LONG_CYCLES SHALL be greater than DEB_CYCLES; other values are out of scope.

Reset
REQ-029 rst low SHALL immediately force the FSM to IDLE, both counters to 0, long_flag to 0, and the synchronizer flops to 1.
REQ-030 rst low SHALL immediately force pressed, press_pulse, short_pulse, long_pulse and run to 0.
REQ-031 Reset asserted mid-press SHALL emit no strobes. After release of reset, a still-held button SHALL be treated as a new press.

Verification (DEB_CYCLES=4, LONG_CYCLES=20)
REQ-032 Reset with pb_n=1 -> all outputs 0 and state IDLE for 50 cycles.
REQ-033 pb_n low 3 cycles then high -> no press_pulse, pressed stays 0, run stays 0.
REQ-034 pb_n low 12 cycles then high -> press_pulse exactly once, 7 cycles after the fall. Then short_pulse once and run 0->1, 7 cycles after the rise. A second identical press -> run 1->0.
REQ-035 pb_n low 40 cycles -> press_pulse once and long_pulse once, 20 cycles after press_pulse. On release: no short_pulse, run unchanged, pressed drops.
REQ-036 Short press with pb_n toggling 1/0 every cycle for 6 cycles at release, then high -> exactly one short_pulse, and pressed stays 1 through the bounce.
REQ-037 pb_n held low, rst pulsed low 2 cycles at hold_cnt=10 -> outputs 0 during reset, no long_pulse at old timing, and a fresh press_pulse 7 cycles after rst rises.
